// File: rtl/ahblite_slave_mux.sv
// AHB-Lite response multiplexer: routes the selected slave's data-phase response back to the master,
// and provides a built-in default slave that answers unmapped or disabled accesses with a two-cycle ERROR.
module ahblite_slave_mux #(
    parameter bit Port0_en = 1'b1,
    parameter bit Port1_en = 1'b1,
    parameter bit Port2_en = 1'b1,
    parameter bit Port3_en = 1'b1,
    parameter bit Port4_en = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,

    input  logic        P0_HSEL,
    input  logic        P1_HSEL,
    input  logic        P2_HSEL,
    input  logic        P3_HSEL,
    input  logic        P4_HSEL,

    input  logic        P0_HREADYOUT,
    input  logic        P1_HREADYOUT,
    input  logic        P2_HREADYOUT,
    input  logic        P3_HREADYOUT,
    input  logic        P4_HREADYOUT,

    input  logic        P0_HRESP,
    input  logic        P1_HRESP,
    input  logic        P2_HRESP,
    input  logic        P3_HRESP,
    input  logic        P4_HRESP,

    input  logic [31:0] P0_HRDATA,
    input  logic [31:0] P1_HRDATA,
    input  logic [31:0] P2_HRDATA,
    input  logic [31:0] P3_HRDATA,
    input  logic [31:0] P4_HRDATA,

    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA,

    input  logic        ERR_CLR,
    output logic [15:0] ERR_CNT,
    output logic [31:0] ERR_ADDR
);

    localparam int NPORTS = 5;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [NPORTS-1:0] PORT_EN = {Port4_en, Port3_en, Port2_en, Port1_en, Port0_en};

    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } def_state_t;

    def_state_t        def_state;
    logic [NPORTS-1:0] sel_q;

    logic [NPORTS-1:0] hsel_v;
    logic [NPORTS-1:0] hreadyout_v;
    logic [NPORTS-1:0] hresp_v;
    logic [31:0]       hrdata_v [NPORTS];

    logic [NPORTS-1:0] en_sel;
    logic              active;
    logic              sample;
    logic              unmapped;
    logic              err_inc;

    assign hsel_v      = {P4_HSEL, P3_HSEL, P2_HSEL, P1_HSEL, P0_HSEL};
    assign hreadyout_v = {P4_HREADYOUT, P3_HREADYOUT, P2_HREADYOUT, P1_HREADYOUT, P0_HREADYOUT};
    assign hresp_v     = {P4_HRESP, P3_HRESP, P2_HRESP, P1_HRESP, P0_HRESP};

    assign hrdata_v[0] = P0_HRDATA;
    assign hrdata_v[1] = P1_HRDATA;
    assign hrdata_v[2] = P2_HRDATA;
    assign hrdata_v[3] = P3_HRDATA;
    assign hrdata_v[4] = P4_HRDATA;

    // A disabled port looks exactly like unmapped space to the rest of the logic.
    assign en_sel   = hsel_v & PORT_EN;
    assign active   = (HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ);
    assign sample   = HREADY;
    assign unmapped = (en_sel == '0) && active;
    assign err_inc  = sample && unmapped;

    // Data-phase response; lowest-index select wins if the decoder ever misbehaves.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block can infer a latch.
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (def_state)
            DEF_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            DEF_ERR2: begin
                HREADY = 1'b1;
                HRESP  = 1'b1;
            end
            default: begin
                for (int i = NPORTS - 1; i >= 0; i--) begin
                    if (sel_q[i]) begin
                        HREADY = hreadyout_v[i];
                        HRESP  = hresp_v[i];
                        HRDATA = hrdata_v[i];
                    end
                end
            end
        endcase
    end

    // Select register and default-slave FSM; both advance only on an address-phase sample.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            // NOTE: state uses non-blocking assignments so every flop sees pre-edge values of the others.
            sel_q     <= '0;
            def_state <= DEF_IDLE;
        end else begin
            if (sample) begin
                sel_q <= en_sel;
            end
            case (def_state)
                DEF_IDLE: if (err_inc) def_state <= DEF_ERR1;
                DEF_ERR1: def_state <= DEF_ERR2;
                DEF_ERR2: def_state <= err_inc ? DEF_ERR1 : DEF_IDLE;
                default:  def_state <= DEF_IDLE;
            endcase
        end
    end

    // Error log: an increment in the same cycle as a clear restarts the log at this error.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ERR_CNT  <= '0;
            ERR_ADDR <= '0;
        end else if (err_inc) begin
            ERR_ADDR <= HADDR;
            if (ERR_CLR) begin
                ERR_CNT <= 16'd1;
            end else if (ERR_CNT != 16'hFFFF) begin
                ERR_CNT <= ERR_CNT + 16'd1;
            end
        end else if (ERR_CLR) begin
            ERR_CNT  <= '0;
            ERR_ADDR <= '0;
        end
    end

endmodule

// File: doc/ahblite_slave_mux.md
Name: ahblite_slave_mux

Overview:
AHB-Lite response-side multiplexer that pairs with the address decoder. It registers the decoder's select vector in the address phase. In the data phase it routes the selected slave's HRDATA, HREADYOUT and HRESP back to the master as HRDATA, HREADY and HRESP. It contains a built-in default slave that returns the protocol two-cycle ERROR response for active transfers to unmapped or disabled regions, and it logs those errors for debug.

Parameters:
Port0_en, 1, enable for port 0 (RAMCODE); 0 means the port is treated as unmapped
Port1_en, 1, enable for port 1 (RAMDATA)
Port2_en, 1, enable for port 2 (peripheral)
Port3_en, 1, enable for port 3 (UART)
Port4_en, 1, enable for port 4 (GPIO)

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HADDR  input  32  master address (address phase)
HTRANS  input  2  master transfer type
P0_HSEL..P4_HSEL  input  1 each  decoder selects (address phase)
P0_HREADYOUT..P4_HREADYOUT  input  1 each  slave ready
P0_HRESP..P4_HRESP  input  1 each  slave response (0 OKAY, 1 ERROR)
P0_HRDATA..P4_HRDATA  input  32 each  slave read data
HREADY  output  1  global ready to master and all slaves
HRESP  output  1  response to master
HRDATA  output  32  read data to master
ERR_CLR  input  1  synchronous clear of the error log
ERR_CNT  output  16  count of default-slave ERROR responses, saturating
ERR_ADDR  output  32  HADDR of the most recent unmapped active transfer

Behaviour:
- Clocking and reset: single clock HCLK; HRESETn asynchronous, active-low.
- Reset values: sel_q=0, def state IDLE, HREADY=1, HRESP=0, HRDATA=0, ERR_CNT=0, ERR_ADDR=0.
- Effective select: en_sel[i] = Pi_HSEL & Porti_en.
- Address-phase sample: happens only on a rising HCLK with HREADY=1.
  - sel_q <= en_sel.
  - unmapped = (en_sel==0) & HTRANS[1] (NONSEQ or SEQ).
- Multi-hot sel_q: lowest index wins. The decoder is required to be one-hot, and this tie-break is deterministic only.
- Data-phase routing is combinational from registered state, with no added latency:
  - sel_q bit i set: HREADY=Pi_HREADYOUT, HRESP=Pi_HRESP, HRDATA=Pi_HRDATA.
  - sel_q=0 and def state IDLE: HREADY=1, HRESP=0, HRDATA=0. This covers IDLE/BUSY transfers to unmapped space, which get a zero-wait OKAY.
- Default-slave FSM (states IDLE, ERR1, ERR2):
  - IDLE -> ERR1 on an address-phase sample with unmapped=1.
  - ERR1: HREADY=0, HRESP=1, HRDATA=0. Always -> ERR2 next cycle.
  - ERR2: HREADY=1, HRESP=1, HRDATA=0.
    - -> ERR1 if the sample in this cycle is unmapped=1 (back-to-back errors).
    - Else -> IDLE; sel_q is loaded normally.
  - HREADY=0 in ERR1 freezes sel_q. A master changing HTRANS to IDLE during ERR1 has no effect until the ERR2 sample.
- Slave wait states: while the selected slave drives HREADYOUT=0, sel_q holds and the FSM stays IDLE.
- A slave two-cycle ERROR is passed through unchanged.
- Error log:
  - On each IDLE->ERR1 or ERR2->ERR1 transition: ERR_ADDR <= HADDR; ERR_CNT <= ERR_CNT+1, saturating at 16'hFFFF (no wrap).
  - ERR_CLR=1 and no increment in the same cycle: ERR_CNT <= 0, ERR_ADDR <= 0.
  - ERR_CLR=1 and an increment in the same cycle: ERR_CNT <= 1, ERR_ADDR <= new HADDR.
- Reset asserted mid-operation (including ERR1/ERR2): immediate return to reset values; no ERROR cycle completes.

Test Plan:
- Reset then NONSEQ to 0x0000_0100 with P0_HSEL=1, P0_HRDATA=0xDEADBEEF, P0_HREADYOUT=1 -> next cycle HRDATA=0xDEADBEEF, HREADY=1, HRESP=0, ERR_CNT=0.
- NONSEQ to 0x2000_0004 with P1 inserting 2 wait states (P1_HREADYOUT=0,0,1) -> HREADY low for 2 cycles then high; a P0 select presented during the waits is ignored until HREADY=1.
- NONSEQ to 0x5000_0000 with no HSEL -> cycle+1: HREADY=0, HRESP=1; cycle+2: HREADY=1, HRESP=1; ERR_CNT=1, ERR_ADDR=0x5000_0000.
- Two back-to-back unmapped NONSEQs (second sampled in ERR2) -> ERR1, ERR2, ERR1, ERR2 with no IDLE between; ERR_CNT=2. Repeat with Port2_en=0 and P2_HSEL=1 -> same ERROR sequence.
- IDLE transfer (HTRANS=00) to an unmapped address -> HREADY=1, HRESP=0, ERR_CNT unchanged. With ERR_CNT preloaded to 0xFFFF via 65535 errors, one more error -> ERR_CNT stays 0xFFFF.
- ERR_CLR pulsed in the same cycle as an unmapped sample -> ERR_CNT=1. HRESETn dropped while in ERR1 -> HREADY=1, HRESP=0 asynchronously, ERR_CNT=0.
